// File: rtl/ekf_stage_sequencer.sv
// Stage sequencer for the EKF-SLAM Top: buffers one observation frame, issues PRD per odometry
// beat until the timestamps line up, then NEW/ASSOC once per buffered feature.
module ekf_stage_sequencer #(
  parameter int RSA_DW   = 32,
  parameter int TS_DW    = 32,
  parameter int MAX_FEAT = 20,
  parameter int FEAT_AW  = 5,
  parameter int SYNC_WIN = 20,
  parameter int VAL_HOLD = 2
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [15:0]       frame_max,
  input  logic              odo_valid,
  output logic              odo_ready,
  input  logic [RSA_DW-1:0] odo_vlr,
  input  logic [RSA_DW-1:0] odo_alpha,
  input  logic [TS_DW-1:0]  odo_time,
  input  logic              obs_valid,
  output logic              obs_ready,
  input  logic [RSA_DW-1:0] obs_rk,
  input  logic [RSA_DW-1:0] obs_phi,
  input  logic [TS_DW-1:0]  obs_time,
  input  logic              obs_last,
  input  logic              obs_nofeat,
  output logic [2:0]        stage_val,
  output logic [RSA_DW-1:0] vlr,
  output logic [RSA_DW-1:0] alpha,
  output logic [RSA_DW-1:0] rk,
  output logic [RSA_DW-1:0] phi,
  input  logic              stage_rdy,
  output logic              busy,
  output logic              done,
  output logic              init_done,
  output logic              ovf_err
);

  localparam int HOLD_W = (VAL_HOLD > 1) ? $clog2(VAL_HOLD) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_OBS,
    S_FETCH_ODO,
    S_ISSUE_PRD,
    S_WAIT_PRD,
    S_CHECK,
    S_ISSUE_FEAT,
    S_WAIT_FEAT,
    S_DONE
  } state_t;

  typedef logic signed [TS_DW:0] ts_diff_t;
  localparam ts_diff_t SYNC_WIN_S = ts_diff_t'(SYNC_WIN);

  state_t            r_state;
  state_t            w_next;
  logic [HOLD_W-1:0] r_hold;
  logic [FEAT_AW-1:0] r_feat_cnt;
  logic [FEAT_AW-1:0] r_feat_idx;
  logic              r_first_beat;
  logic [TS_DW-1:0]  r_obs_time;
  logic [TS_DW-1:0]  r_odo_time;
  logic [RSA_DW-1:0] r_vlr;
  logic [RSA_DW-1:0] r_alpha;
  logic [RSA_DW-1:0] r_rk;
  logic [RSA_DW-1:0] r_phi;
  logic              r_init_pend;
  logic              r_init_done;
  logic              r_ovf_err;
  logic [15:0]       r_frame_cnt;
  logic [RSA_DW-1:0] r_buf_rk  [MAX_FEAT];
  logic [RSA_DW-1:0] r_buf_phi [MAX_FEAT];

  logic              w_odo_fire;
  logic              w_obs_fire;
  logic              w_issue;
  logic              w_hold_end;
  ts_diff_t          w_diff;
  logic              w_match;
  logic [15:0]       w_frame_nxt;
  logic              w_budget_hit;
  logic [FEAT_AW-1:0] w_idx_nxt;
  logic [FEAT_AW-1:0] w_rd_idx;
  logic              w_last_feat;
  logic              w_buf_full;
  logic              w_store;
  logic              w_feat_done;
  logic              w_enter_load;
  logic              w_load_feat;

  // Handshakes drop the moment abort rises so no beat is taken on the abort cycle.
  assign odo_ready  = (r_state == S_FETCH_ODO) && !abort;
  assign obs_ready  = (r_state == S_LOAD_OBS) && !abort;
  assign w_odo_fire = odo_valid && odo_ready;
  assign w_obs_fire = obs_valid && obs_ready;

  assign w_issue    = (r_state == S_ISSUE_PRD) || (r_state == S_ISSUE_FEAT);
  assign w_hold_end = (r_hold == HOLD_W'(VAL_HOLD - 1));

  // One extra bit so an observation older than the odometry comes out negative and matches.
  assign w_diff  = ts_diff_t'({1'b0, r_obs_time} - {1'b0, r_odo_time});
  assign w_match = (w_diff <= SYNC_WIN_S);

  assign w_frame_nxt  = r_frame_cnt + 16'd1;
  assign w_budget_hit = (frame_max != 16'd0) && (w_frame_nxt == frame_max);

  assign w_idx_nxt   = r_feat_idx + FEAT_AW'(1);
  assign w_rd_idx    = (r_state == S_CHECK) ? '0 : w_idx_nxt;
  assign w_last_feat = (w_idx_nxt == r_feat_cnt);
  assign w_buf_full  = (r_feat_cnt == FEAT_AW'(MAX_FEAT));
  assign w_store     = w_obs_fire && !obs_nofeat && !w_buf_full;
  assign w_feat_done = (r_state == S_WAIT_FEAT) && stage_rdy && !abort;

  assign w_enter_load = (w_next == S_LOAD_OBS) && (r_state != S_LOAD_OBS);
  assign w_load_feat  = (w_next == S_ISSUE_FEAT) && (r_state != S_ISSUE_FEAT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (start) w_next = S_LOAD_OBS;
      S_LOAD_OBS:   if (w_obs_fire && obs_last) w_next = S_FETCH_ODO;
      S_FETCH_ODO:  if (w_odo_fire) w_next = S_ISSUE_PRD;
      S_ISSUE_PRD:  if (w_hold_end) w_next = S_WAIT_PRD;
      S_WAIT_PRD:   if (stage_rdy) w_next = w_budget_hit ? S_DONE : S_CHECK;
      S_CHECK: begin
        if (!w_match)                 w_next = S_FETCH_ODO;
        else if (r_feat_cnt == '0)    w_next = S_LOAD_OBS;
        else                          w_next = S_ISSUE_FEAT;
      end
      S_ISSUE_FEAT: if (w_hold_end) w_next = S_WAIT_FEAT;
      S_WAIT_FEAT:  if (stage_rdy) w_next = w_last_feat ? S_LOAD_OBS : S_ISSUE_FEAT;
      S_DONE:       if (!start) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_comb begin
    stage_val = 3'd0;
    if (!abort) begin
      if (r_state == S_ISSUE_PRD)  stage_val = 3'd1;
      if (r_state == S_ISSUE_FEAT) stage_val = r_init_pend ? 3'd2 : 3'd4;
    end
  end

  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done      = (r_state == S_DONE);
  assign vlr       = r_vlr;
  assign alpha     = r_alpha;
  assign rk        = r_rk;
  assign phi       = r_phi;
  assign init_done = r_init_done;
  assign ovf_err   = r_ovf_err;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_hold       <= '0;
      r_feat_cnt   <= '0;
      r_feat_idx   <= '0;
      r_first_beat <= 1'b1;
      r_obs_time   <= '0;
      r_odo_time   <= '0;
      r_vlr        <= '0;
      r_alpha      <= '0;
      r_rk         <= '0;
      r_phi        <= '0;
      r_init_pend  <= 1'b1;
      r_init_done  <= 1'b0;
      r_ovf_err    <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_state <= w_next;

      if (w_issue && !abort && !w_hold_end) r_hold <= r_hold + HOLD_W'(1);
      else                                  r_hold <= '0;

      if (w_enter_load) begin
        r_feat_cnt   <= '0;
        r_first_beat <= 1'b1;
      end else if (w_obs_fire) begin
        r_first_beat <= 1'b0;
        if (r_first_beat) r_obs_time <= obs_time;
        if (!obs_nofeat) begin
          if (w_buf_full) r_ovf_err  <= 1'b1;
          else            r_feat_cnt <= r_feat_cnt + FEAT_AW'(1);
        end
      end

      if (w_odo_fire) begin
        r_vlr      <= odo_vlr;
        r_alpha    <= odo_alpha;
        r_odo_time <= odo_time;
      end

      if (r_state == S_CHECK) r_feat_idx <= '0;
      else if (w_feat_done)   r_feat_idx <= w_idx_nxt;

      // Operands are fetched one cycle ahead so they are stable on the first issue cycle.
      if (w_load_feat) begin
        r_rk  <= r_buf_rk[w_rd_idx];
        r_phi <= r_buf_phi[w_rd_idx];
      end

      if (abort || (r_state == S_DONE && !start)) begin
        r_frame_cnt <= '0;
        r_init_pend <= 1'b1;
      end else begin
        if (r_state == S_WAIT_PRD && stage_rdy) r_frame_cnt <= w_frame_nxt;
        if (w_feat_done && w_last_feat) begin
          r_init_pend <= 1'b0;
          r_init_done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_store) begin
      r_buf_rk[r_feat_cnt]  <= obs_rk;
      r_buf_phi[r_feat_cnt] <= obs_phi;
    end
  end

endmodule
